mmio_uart_tx: RTL

- Memory-mapped UART transmitter peripheral; responder on the CPU data bus alongside the switch-input and seven-segment registers.
- CPU stores bytes to TXDATA. The block queues them in a small FIFO and serialises them 8N1, LSB first, on tx.
- Status and control registers are readable through a combinational read port, which the top level muxes into the CPU's Data_in path.

---
 rtl/mmio_uart_tx.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/CTRL register window in front
// of a small circular FIFO feeding a start/data/stop serialiser.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR       = 32'hFFFF0010,
    parameter int unsigned CLKS_PER_BIT    = 868,
    parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_w,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        busy
);
    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned PW    = FIFO_DEPTH_LOG2;
    localparam int unsigned CW    = FIFO_DEPTH_LOG2 + 1;

    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [15:0]   BC_RELOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [29:0]   W_TXDATA  = BASE_ADDR[31:2];
    localparam logic [29:0]   W_STATUS  = W_TXDATA + 30'd1;
    localparam logic [29:0]   W_CTRL    = W_TXDATA + 30'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_enable;

    state_t        r_state;
    state_t        w_state_next;
    logic [15:0]   r_bc;
    logic [15:0]   w_bc_next;
    logic [2:0]    r_bi;
    logic [2:0]    w_bi_next;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_next;
    logic          r_tx;
    logic          w_tx_next;

    logic          w_sel_txdata;
    logic          w_sel_status;
    logic          w_sel_ctrl;
    logic          w_push;
    logic          w_push_ok;
    logic          w_pop;
    logic          w_can_pop;
    logic          w_flush;
    logic          w_wr_status;
    logic          w_wr_ctrl;
    logic          w_full;
    logic          w_empty;
    logic          w_busy;
    logic [7:0]    w_head;
    logic [3:0]    w_count4;
    logic          w_unused;

    // Decode ignores the byte-lane bits so any byte address in a word selects it.
    assign w_sel_txdata = (addr[31:2] == W_TXDATA);
    assign w_sel_status = (addr[31:2] == W_STATUS);
    assign w_sel_ctrl   = (addr[31:2] == W_CTRL);
    assign hit          = w_sel_txdata | w_sel_status | w_sel_ctrl;

    assign w_push      = mem_w & w_sel_txdata;
    assign w_wr_status = mem_w & w_sel_status;
    assign w_wr_ctrl   = mem_w & w_sel_ctrl;
    assign w_flush     = w_wr_ctrl & wdata[1];

    assign w_full    = (r_count == DEPTH_C);
    assign w_empty   = (r_count == '0);
    assign w_push_ok = w_push & ~w_full;
    assign w_can_pop = ~w_empty & r_enable;
    assign w_head    = r_mem[r_rd_ptr];
    assign w_busy    = (r_state != S_IDLE) | ~w_empty;

    generate
        if (CW >= 4) begin : g_count_wide
            assign w_count4 = r_count[3:0];
        end else begin : g_count_narrow
            assign w_count4 = {{(4 - CW){1'b0}}, r_count};
        end
    endgenerate

    assign w_unused = &{1'b0, addr[1:0], wdata[31:8]};

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_enable   <= 1'b1;
        end else begin
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push_ok) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                if (w_push_ok && !w_pop) begin
                    r_count <= r_count + CW'(1);
                end else if (!w_push_ok && w_pop) begin
                    r_count <= r_count - CW'(1);
                end
            end
            // Full is judged before the edge, so a same-cycle pop never rescues a push.
            if (w_push && w_full) begin
                r_overflow <= 1'b1;
            end else if (w_wr_status) begin
                r_overflow <= 1'b0;
            end
            if (w_wr_ctrl) begin
                r_enable <= wdata[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_bc    <= '0;
            r_bi    <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_bc    <= w_bc_next;
            r_bi    <= w_bi_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_bc_next    = r_bc;
        w_bi_next    = r_bi;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        w_tx_next    = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_can_pop) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_bc_next    = BC_RELOAD;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (r_bc == '0) begin
                    w_bc_next    = BC_RELOAD;
                    w_bi_next    = '0;
                    w_state_next = S_DATA;
                end else begin
                    w_bc_next = r_bc - 16'd1;
                end
            end
            S_DATA: begin
                if (r_bc == '0) begin
                    w_shift_next = {1'b0, r_shift[7:1]};
                    w_bc_next    = BC_RELOAD;
                    if (r_bi == 3'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bi_next = r_bi + 3'd1;
                    end
                end else begin
                    w_bc_next = r_bc - 16'd1;
                end
            end
            S_STOP: begin
                if (r_bc == '0) begin
                    // Chain straight into the next start bit when more data is waiting.
                    if (w_can_pop) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_head;
                        w_bc_next    = BC_RELOAD;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_bc_next = r_bc - 16'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        case (w_state_next)
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    always_comb begin
        rdata = '0;
        if (w_sel_status) begin
            rdata[7:0] = {w_count4, r_overflow, w_busy, w_empty, w_full};
        end else if (w_sel_ctrl) begin
            rdata[0] = r_enable;
        end
    end

    assign tx   = r_tx;
    assign busy = w_busy;

endmodule
